// File: rtl/debug_ram_master.sv
// rtl/debug_ram_master.sv - burst initiator for the core's DataRAM/InstRAM port-2 debug access
// Writes pass straight through to the selected port; reads run through a 2-entry fall-through FIFO.
module debug_ram_master #(
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic             cmd_sel,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             done,
  output logic [31:0]      dram_a2,
  output logic [31:0]      iram_a2,
  output logic [31:0]      dram_wd2,
  output logic [31:0]      iram_wd2,
  output logic [3:0]       dram_we2,
  output logic [3:0]       iram_we2,
  input  logic [31:0]      dram_rd2,
  input  logic [31:0]      iram_rd2
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [31:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              hold_q, hold_d;
  logic [RD_LAT-1:0] infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0][31:0]  fifo_data_q, fifo_data_d;
  logic [1:0]        fifo_last_q, fifo_last_d;
  logic [1:0]        occ_q, occ_d;

  logic              wr_fire, issue, pop, push, arrive, arr_last;
  logic [31:0]       arr_data;
  logic [RD_LAT-1:0] issue_vec, issue_last_vec;
  int                reserved;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    hold_d         = 1'b0;
    fifo_data_d    = fifo_data_q;
    fifo_last_d    = fifo_last_q;
    occ_d          = occ_q;
    issue_vec      = '0;
    issue_last_vec = '0;

    busy      = (state_q != IDLE);
    done      = done_q;
    cmd_ready = (state_q == IDLE) && !done_q && !hold_q;
    wr_ready  = (state_q == WRITE) && !rst;
    wr_fire   = wr_valid && wr_ready;

    // A word arriving from port 2 can be handed to the consumer in the same cycle.
    arrive    = infl_q[RD_LAT-1];
    arr_last  = infl_last_q[RD_LAT-1];
    arr_data  = sel_q ? iram_rd2 : dram_rd2;
    rsp_valid = (occ_q != 2'd0) || arrive;
    rsp_data  = (occ_q != 2'd0) ? fifo_data_q[0] : arr_data;
    rsp_last  = (occ_q != 2'd0) ? fifo_last_q[0] : arr_last;
    pop       = rsp_valid && rsp_ready;
    push      = arrive && !((occ_q == 2'd0) && pop);

    // Every issued word owns a FIFO slot until popped, so nothing returning is ever dropped.
    reserved  = int'(occ_q) + $countones(infl_q) - (pop ? 1 : 0);
    issue     = (state_q == READ) && (reserved < 2) && !rst;
    issue_vec[0]      = issue;
    issue_last_vec[0] = issue && (cnt_q == '0);
    infl_d      = (infl_q << 1) | issue_vec;
    infl_last_d = (infl_last_q << 1) | issue_last_vec;

    if (pop && (occ_q != 2'd0)) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_last_d[0] = fifo_last_q[1];
      occ_d          = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) begin
        fifo_data_d[0] = arr_data;
        fifo_last_d[0] = arr_last;
      end else begin
        fifo_data_d[1] = arr_data;
        fifo_last_d[1] = arr_last;
      end
      occ_d = occ_d + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          sel_d   = cmd_sel;
          addr_d  = cmd_addr & 32'hFFFF_FFFC;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + 32'd4;
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_q + 32'd4;
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && rsp_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    dram_a2  = (busy && !sel_q) ? addr_q : '0;
    iram_a2  = (busy && sel_q) ? addr_q : '0;
    dram_wd2 = (wr_fire && !sel_q) ? wr_data : '0;
    iram_wd2 = (wr_fire && sel_q) ? wr_data : '0;
    dram_we2 = (wr_fire && !sel_q) ? wr_be : '0;
    iram_we2 = (wr_fire && sel_q) ? wr_be : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      hold_q      <= 1'b1;
      infl_q      <= '0;
      infl_last_q <= '0;
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      occ_q       <= occ_d;
    end
  end

endmodule

// File: tb/tb_debug_ram_master.sv
// tb/tb_debug_ram_master.sv - directed bench for debug_ram_master with behavioural port-2 RAMs
// Inputs change 1 time unit after posedge; outputs are sampled 3 units after posedge.
module tb_debug_ram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_sel;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic        busy, done;
  logic [31:0] dram_a2, iram_a2, dram_wd2, iram_wd2;
  logic [3:0]  dram_we2, iram_we2;
  logic [31:0] dram_rd2 = '0;
  logic [31:0] iram_rd2 = '0;

  int checks = 0;
  int errors = 0;

  debug_ram_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .done(done),
    .dram_a2(dram_a2), .iram_a2(iram_a2), .dram_wd2(dram_wd2), .iram_wd2(iram_wd2),
    .dram_we2(dram_we2), .iram_we2(iram_we2), .dram_rd2(dram_rd2), .iram_rd2(iram_rd2)
  );

  always #5 clk = ~clk;

  // Port-2 RAM models: 256 words each, read data registered one cycle after the address.
  logic [31:0] dmem [256];
  logic [31:0] imem [256];
  logic [31:0] d_next = '0;
  logic [31:0] i_next = '0;
  bit          mem_init = 1'b0;
  int          dram_wr_cnt = 0;
  int          iram_wr_cnt = 0;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) begin
        dmem[i] = 32'h0BAD_0000 | i;
        imem[i] = 32'hA000_0000 | i;
      end
      for (int i = 16; i < 19; i++) dmem[i] = 32'hFFFF_FFFF;
      mem_init = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      if (dram_we2[b]) dmem[dram_a2[9:2]][8*b +: 8] = dram_wd2[8*b +: 8];
      if (iram_we2[b]) imem[iram_a2[9:2]][8*b +: 8] = iram_wd2[8*b +: 8];
    end
    if (dram_we2 != 4'h0) dram_wr_cnt++;
    if (iram_we2 != 4'h0) iram_wr_cnt++;
    d_next = dmem[dram_a2[9:2]];
    i_next = imem[iram_a2[9:2]];
  end

  always @(posedge clk) begin
    dram_rd2 <= d_next;
    iram_rd2 <= i_next;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the command until accepted; returns 1 unit into the first cycle after acceptance.
  task automatic accept(input logic w, input logic s, input logic [31:0] a, input logic [7:0] l);
    logic ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_sel   = s;
    cmd_addr  = a;
    cmd_len   = l;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("cmd_accept", ok, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [31:0] wdat [4];
  logic [31:0] pdat [3];
  logic [4:0]  vpat;
  logic [3:0]  bp_pat;
  int          n, hs;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_be = '0; rsp_ready = 1'b1;
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    pdat[0] = 32'h1234_ABCD; pdat[1] = 32'h5678_EF01; pdat[2] = 32'h9ABC_2345;
    vpat = 5'b11001;
    bp_pat = 4'b1001;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_dram_a2", dram_a2, 32'h0);
    chk("rst_iram_we2", iram_we2, 4'h0);

    // Write burst of 4 words to DataRAM.
    accept(1'b1, 1'b0, 32'h100, 8'd3);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = wdat[i]; wr_be = 4'hF;
      #2;
      chk("wr_dram_we2", dram_we2, 4'hF);
      chk("wr_dram_a2", dram_a2, 32'h100 + 4 * i);
      chk("wr_dram_wd2", dram_wd2, wdat[i]);
      chk("wr_iram_we2", iram_we2, 4'h0);
      chk("wr_busy", busy, 1'b1);
      tick();
    end
    wr_valid = 1'b0;
    #2;
    chk("wr_done", done, 1'b1);
    chk("wr_busy_fall", busy, 1'b0);
    chk("wr_cmd_ready_done", cmd_ready, 1'b0);
    tick();
    #2;
    chk("wr_done_pulse", done, 1'b0);
    chk("wr_cmd_ready_back", cmd_ready, 1'b1);
    chk("wr_count", dram_wr_cnt, 4);
    chk("wr_iram_count", iram_wr_cnt, 0);

    // Read back at full rate.
    rsp_ready = 1'b1;
    accept(1'b0, 1'b0, 32'h100, 8'd3);
    #2;
    chk("rd_first_cycle_valid", rsp_valid, 1'b0);
    chk("rd_first_a2", dram_a2, 32'h100);
    tick();
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rd_valid", rsp_valid, 1'b1);
      chk("rd_data", rsp_data, wdat[i]);
      chk("rd_last", rsp_last, i == 3);
      tick();
    end
    #2;
    chk("rd_done", done, 1'b1);
    chk("rd_busy", busy, 1'b0);
    chk("rd_valid_after", rsp_valid, 1'b0);

    // InstRAM read with back-pressure.
    accept(1'b0, 1'b1, 32'h200, 8'd7);
    n = 0;
    for (int k = 0; k < 60 && n < 8; k++) begin
      rsp_ready = bp_pat[k % 4];
      #2;
      if (rsp_valid && rsp_ready) begin
        chk("bp_data", rsp_data, 32'hA000_0080 + n);
        chk("bp_last", rsp_last, n == 7);
        n++;
      end
      tick();
    end
    chk("bp_count", n, 8);
    rsp_ready = 1'b1;
    #2;
    chk("bp_done", done, 1'b1);
    chk("bp_valid_after", rsp_valid, 1'b0);

    // Misaligned start address and 32-bit wrap.
    accept(1'b1, 1'b0, 32'hFFFF_FFFB, 8'd1);
    wr_valid = 1'b1; wr_data = 32'hDEAD_0001; wr_be = 4'hF;
    #2;
    chk("wrap_wr_a2_0", dram_a2, 32'hFFFF_FFF8);
    tick();
    wr_data = 32'hDEAD_0002;
    #2;
    chk("wrap_wr_a2_1", dram_a2, 32'hFFFF_FFFC);
    tick();
    wr_valid = 1'b0;
    accept(1'b0, 1'b0, 32'hFFFF_FFFC, 8'd2);
    #2;
    chk("wrap_rd_a2_0", dram_a2, 32'hFFFF_FFFC);
    tick();
    #2;
    chk("wrap_rd_a2_1", dram_a2, 32'h0);
    chk("wrap_rd_data_0", rsp_data, 32'hDEAD_0002);
    tick();
    #2;
    chk("wrap_rd_a2_2", dram_a2, 32'h4);
    chk("wrap_rd_data_1", rsp_data, 32'h0BAD_0000);
    tick();
    #2;
    chk("wrap_rd_data_2", rsp_data, 32'h0BAD_0001);
    chk("wrap_rd_last", rsp_last, 1'b1);
    tick();
    #2;
    chk("wrap_rd_done", done, 1'b1);

    // Partial byte enables with gaps in wr_valid.
    accept(1'b1, 1'b0, 32'h40, 8'd2);
    hs = 0;
    for (int j = 0; j < 5; j++) begin
      wr_valid = vpat[j]; wr_be = 4'h3; wr_data = pdat[hs];
      #2;
      chk("pbe_we2", dram_we2, vpat[j] ? 4'h3 : 4'h0);
      if (vpat[j]) begin
        chk("pbe_a2", dram_a2, 32'h40 + 4 * hs);
        hs++;
      end
      tick();
    end
    wr_valid = 1'b0;
    #2;
    chk("pbe_done", done, 1'b1);
    accept(1'b0, 1'b0, 32'h40, 8'd1);
    tick();
    #2;
    chk("pbe_rd_0", rsp_data, 32'hFFFF_ABCD);
    tick();
    #2;
    chk("pbe_rd_1", rsp_data, 32'hFFFF_EF01);
    chk("pbe_rd_last", rsp_last, 1'b1);
    tick();

    // Reset in the middle of an InstRAM write burst.
    accept(1'b1, 1'b1, 32'h300, 8'd3);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_be = 4'hF; wr_data = 32'h5500_0000 + i;
      #2;
      chk("mid_iram_we2", iram_we2, 4'hF);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_wr_ready", wr_ready, 1'b0);
    chk("mid_rst_iram_we2", iram_we2, 4'h0);
    chk("mid_rst_iram_a2", iram_a2, 32'h0);
    chk("mid_rst_iram_wd2", iram_wd2, 32'h0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    #2;
    chk("mid_rst_cmd_ready_back", cmd_ready, 1'b1);
    chk("mid_rst_iram_count", iram_wr_cnt, 2);
    wr_valid = 1'b0;
    accept(1'b0, 1'b1, 32'h200, 8'd0);
    tick();
    #2;
    chk("post_rst_rd_data", rsp_data, 32'hA000_0080);
    chk("post_rst_rd_last", rsp_last, 1'b1);
    tick();
    #2;
    chk("post_rst_done", done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_ram_master.md
Name: debug_ram_master

Overview:
Host-side initiator for the core's debug memory ports (DataRAM and InstRAM port 2). It turns a command stream from the board-level loader (program load, memory dump) into word accesses on A2/WD2/WE2, and returns RD2 read data on a back-pressured response stream. Both RAM port-2 interfaces are driven from this single block, one at a time. The block sits beside the CPU core in the top-level wrapper.

Parameters:
LEN_W, 8, width of burst length field; a burst is cmd_len+1 words (1..256 by default).
RD_LAT, 1, RAM port-2 read latency in cycles; only 1 is supported.

Ports:
clk  in  1  clock, shared with the core.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command accepted when valid&ready.
cmd_write  in  1  1=write burst, 0=read burst.
cmd_sel  in  1  0=DataRAM, 1=InstRAM.
cmd_addr  in  32  start byte address; bits[1:0] ignored, forced 0.
cmd_len  in  LEN_W  words minus one.
wr_valid  in  1  write word offered.
wr_ready  out  1  write word consumed when valid&ready.
wr_data  in  32  write word.
wr_be  in  4  byte enables for the word.
rsp_valid  out  1  read word available.
rsp_ready  in  1  consumer takes word when valid&ready.
rsp_data  out  32  read word.
rsp_last  out  1  final word of the burst.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse at burst completion.
dram_a2, iram_a2  out  32  RAM port-2 address.
dram_wd2, iram_wd2  out  32  RAM port-2 write data.
dram_we2, iram_we2  out  4  RAM port-2 byte write enables.
dram_rd2, iram_rd2  in  32  RAM port-2 read data, valid RD_LAT cycles after the address.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. All outputs are 0: cmd_ready, wr_ready, rsp_valid, busy, done, addresses, wd2, we2. The response buffer is emptied and the counters are cleared. Reset mid-burst abandons the burst immediately; no further WE2 is asserted.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch sel, addr&~3, and remaining count=cmd_len. Next state is WRITE or READ according to cmd_write. cmd_ready is 0 in every other state.
- WRITE:
  - wr_ready=1.
  - On each wr handshake, in that same cycle, the selected port drives a2=current addr, wd2=wr_data, we2=wr_be (combinational passthrough).
  - Then addr+=4 (32-bit wrap, 0xFFFFFFFC -> 0x0) and count decrements.
  - The handshake with count==0 pulses done the next cycle and returns to IDLE.
- WE2 rules: we2 is 0 on any cycle without a write handshake and always 0 on the unselected port. The unselected port's a2 and wd2 hold at 0.
- READ:
  - Issue an address on cycle t when (buffer occupancy + in-flight) < 2. Data is captured from the selected rd2 at t+1 into a 2-entry FIFO.
  - Each issue advances addr and count. After the issue with count==0, go to DRAIN.
  - rsp_valid = FIFO non-empty; rsp_data = FIFO head.
  - rsp_last is set on the entry belonging to the final word.
- DRAIN: no further issues. When the FIFO empties after the last pop, pulse done and return to IDLE.
- Throughput: with rsp_ready held at 1, reads sustain 1 word/cycle. The first rsp_valid appears 2 cycles after command acceptance.
- Back-pressure: with rsp_ready=0, issue stops so that no returning word is ever dropped. The FIFO holds at most 2 words.
- Simultaneous push and pop: with the FIFO full, occupancy stays at 2.
- done and rsp_last:
  - done is asserted for exactly 1 cycle per command, in IDLE-bound transition cycle+1.
  - busy falls in the same cycle done rises.
- A new command cannot be accepted in the cycle done is high. cmd_ready returns one cycle later.

Test Plan:
- Write burst: sel=0, addr=0x100, len=3, data 0x11,0x22,0x33,0x44, be=F -> dram_we2=F on 4 cycles at a2=0x100,0x104,0x108,0x10C; iram_we2 stays 0; done 1 pulse.
- Read-back, rsp_ready=1: read the same 4 words -> rsp_data 0x11..0x44 on 4 consecutive cycles; rsp_last only on 0x44; first rsp_valid 2 cycles after accept.
- Back-pressure: InstRAM read, len=7, rsp_ready toggled 1,0,0,1,... -> all 8 words delivered in order, none duplicated or lost, FIFO never exceeds 2.
- Wrap and misalignment: addr=0xFFFFFFFB, len=1, write -> a2=0xFFFFFFF8 then 0xFFFFFFFC; read len=2 from 0xFFFFFFFC -> a2 sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
- Partial enables and wr_valid gaps: be=0x3, wr_valid low 2 cycles mid-burst -> we2=0x3 only on handshake cycles, we2=0 during the gaps.
- Reset mid-burst: rst after 2 of 4 writes -> next cycle all outputs 0, state IDLE, no further we2; a new command is accepted afterwards.
